// File: rtl/cell_tx_arbiter.sv
// Packet-atomic two-source arbiter for one cell-link Aurora TX stream.
// Validates header magic, drops bad packets, aborts stalled ones, keeps per-source statistics.
module cell_tx_arbiter #(
    parameter logic [15:0] MAGIC      = 16'hA5BE,
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [31:0] ABORT_WORD = 32'hDEADDEAD,
    parameter int unsigned CNTW       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     loc_tdata,
    input  logic            loc_tlast,
    input  logic            loc_tvalid,
    output logic            loc_tready,
    input  logic [31:0]     fwd_tdata,
    input  logic            fwd_tlast,
    input  logic            fwd_tvalid,
    output logic            fwd_tready,
    output logic [31:0]     out_tdata,
    output logic            out_tlast,
    output logic            out_tvalid,
    input  logic            out_tready,
    output logic            busy,
    output logic [CNTW-1:0] cnt_loc,
    output logic [CNTW-1:0] cnt_fwd,
    output logic [CNTW-1:0] cnt_drop,
    output logic [CNTW-1:0] cnt_abort
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, PASS, ABORT, FLUSH, DROP} state_t;

    state_t        state, state_nxt;
    logic          grant, grant_nxt;
    logic          last_grant, last_grant_nxt;
    logic [TW-1:0] tmo, tmo_nxt;

    logic          sel;
    logic          g_ready;
    logic [31:0]   g_tdata;
    logic          g_tlast, g_tvalid;
    logic          inc_loc, inc_fwd, inc_drop, inc_abort;

    assign g_tdata  = grant ? fwd_tdata  : loc_tdata;
    assign g_tlast  = grant ? fwd_tlast  : loc_tlast;
    assign g_tvalid = grant ? fwd_tvalid : loc_tvalid;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            tmo        <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            tmo        <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        tmo_nxt        = tmo;
        sel            = 1'b0;
        g_ready        = 1'b0;
        out_tdata      = '0;
        out_tlast      = 1'b0;
        out_tvalid     = 1'b0;
        inc_loc        = 1'b0;
        inc_fwd        = 1'b0;
        inc_drop       = 1'b0;
        inc_abort      = 1'b0;

        case (state)
            IDLE: begin
                tmo_nxt = '0;
                if (loc_tvalid || fwd_tvalid) begin
                    // On a tie the source that did not win last time gets the link
                    sel            = (loc_tvalid && fwd_tvalid) ? ~last_grant : fwd_tvalid;
                    grant_nxt      = sel;
                    last_grant_nxt = sel;
                    if ((sel ? fwd_tdata[31:16] : loc_tdata[31:16]) == MAGIC)
                        state_nxt = PASS;
                    else
                        state_nxt = DROP;
                end
            end
            PASS: begin
                out_tdata  = g_tdata;
                out_tlast  = g_tlast;
                out_tvalid = g_tvalid;
                g_ready    = out_tready;
                if (g_tvalid && out_tready && g_tlast) begin
                    inc_loc   = ~grant;
                    inc_fwd   = grant;
                    state_nxt = IDLE;
                end else if (!g_tvalid) begin
                    if (tmo == TW'(TIMEOUT - 1))
                        state_nxt = ABORT;
                    else
                        tmo_nxt = tmo + TW'(1);
                end else begin
                    tmo_nxt = '0;
                end
            end
            ABORT: begin
                out_tvalid = 1'b1;
                out_tlast  = 1'b1;
                out_tdata  = ABORT_WORD;
                if (out_tready) begin
                    inc_abort = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                g_ready = 1'b1;
                if (g_tvalid && g_tlast)
                    state_nxt = IDLE;
            end
            DROP: begin
                g_ready = 1'b1;
                if (g_tvalid && g_tlast) begin
                    inc_drop  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        loc_tready = g_ready & ~grant;
        fwd_tready = g_ready & grant;
    end

    // Statistics saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_loc   <= '0;
            cnt_fwd   <= '0;
            cnt_drop  <= '0;
            cnt_abort <= '0;
        end else begin
            if (inc_loc && (cnt_loc != '1))
                cnt_loc <= cnt_loc + CNTW'(1);
            if (inc_fwd && (cnt_fwd != '1))
                cnt_fwd <= cnt_fwd + CNTW'(1);
            if (inc_drop && (cnt_drop != '1))
                cnt_drop <= cnt_drop + CNTW'(1);
            if (inc_abort && (cnt_abort != '1))
                cnt_abort <= cnt_abort + CNTW'(1);
        end
    end

endmodule

// File: doc/cell_tx_arbiter.md
Name: cell_tx_arbiter

Overview:
- Packet-atomic arbiter sharing one cell-link Aurora TX AXI stream between two requesters.
  - Source 0 (LOC): locally generated BPM packets.
  - Source 1 (FWD): packets forwarded from the opposite-direction link.
- One instance sits in front of each of the CCW and CW Aurora TX ports.
- Validates the header magic, drops malformed packets, aborts stalled packets, and keeps per-source statistics counters.

Parameters:
- MAGIC, 16'hA5BE, required value of header word bits [31:16].
- TIMEOUT, 64, consecutive mid-packet cycles with granted tvalid low before abort (≥2).
- ABORT_WORD, 32'hDEADDEAD, tdata emitted with tlast=1 to terminate an aborted packet.
- CNTW, 16, width of statistics counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- loc_tdata  in  32  source 0 data.
- loc_tlast  in  1  source 0 end of packet.
- loc_tvalid  in  1  source 0 valid.
- loc_tready  out  1  source 0 ready.
- fwd_tdata  in  32  source 1 data.
- fwd_tlast  in  1  source 1 end of packet.
- fwd_tvalid  in  1  source 1 valid.
- fwd_tready  out  1  source 1 ready.
- out_tdata  out  32  arbitrated output data.
- out_tlast  out  1  output end of packet.
- out_tvalid  out  1  output valid.
- out_tready  in  1  downstream (Aurora) ready.
- busy  out  1  high in any state other than IDLE.
- cnt_loc  out  CNTW  packets from LOC fully forwarded (saturating).
- cnt_fwd  out  CNTW  packets from FWD fully forwarded (saturating).
- cnt_drop  out  CNTW  packets dropped for bad magic (saturating).
- cnt_abort  out  CNTW  packets aborted by timeout (saturating).

Behaviour:
- Reset (async assert, sync deassert at the next clk edge):
  - state=IDLE, grant=0, last_grant=1 (LOC wins the first tie).
  - All counters 0, timeout counter 0.
  - out_tvalid=0, out_tlast=0, out_tdata=0, loc_tready=0, fwd_tready=0, busy=0.
- A handshake on any port is tvalid&tready in the same cycle.
- IDLE:
  - All treadys 0, out_tvalid 0.
  - If exactly one source has tvalid, grant it. If both, grant the source != last_grant.
  - Check the granted source's current tdata[31:16]==MAGIC. Match → PASS; mismatch → DROP. Register grant and update last_grant.
  - Nothing is consumed in IDLE, so there is 1 idle cycle between packets.
- PASS:
  - out_* = granted source tdata/tlast/tvalid, combinational mux.
  - Granted tready = out_tready; the other tready = 0.
  - Output handshake with tlast → increment cnt_loc or cnt_fwd per grant, go to IDLE.
  - Timeout counter increments each cycle granted tvalid=0, clears on granted tvalid=1.
  - Downstream stall (tvalid=1, out_tready=0) does not count toward timeout.
  - Counter reaching TIMEOUT-1 with tvalid still 0 → ABORT.
- ABORT:
  - out_tvalid=1, out_tdata=ABORT_WORD, out_tlast=1; source treadys 0.
  - On out_tready: increment cnt_abort, go to FLUSH.
- FLUSH:
  - Granted tready=1, out_tvalid=0; discard words.
  - Granted tlast handshake → IDLE. Covers the late remainder of the aborted packet.
- DROP:
  - Granted tready=1, out_tvalid=0.
  - Granted tlast handshake → increment cnt_drop, go to IDLE.
  - DROP does not time out.
- A single-word packet (header with tlast=1) is legal in PASS and DROP.
- Counters saturate at all-ones and never wrap.
- A non-granted source's tvalid is ignored until the next IDLE; its data must stay held (AXI rules).
- rst_n asserted mid-packet returns to the reset state immediately; any partial output packet is abandoned (downstream sees tvalid drop).
- out_tdata in IDLE/DROP/FLUSH = 0; out_tlast = 0.

Test Plan:
- LOC only sends a 5-word packet {A5BE0400, FF, FF00, FF0000, ADADFACE}, out_tready=1.
  - → identical 5 words out, tlast on word 5, cnt_loc=1, then IDLE.
- LOC and FWD both assert valid 5-word packets continuously, 3 each.
  - → output order LOC, FWD, LOC, FWD, LOC, FWD.
  - → no interleaving within a packet; cnt_loc=3, cnt_fwd=3.
- FWD header 1234_0000 (bad magic), 5 words.
  - → fwd_tready=1 for 5 cycles, no output valid, cnt_drop=1.
  - → a following good LOC packet passes unaltered.
- LOC sends 2 words, then tvalid=0 for 70 cycles, then 3 words.
  - → after 64 idle cycles output {DEADDEAD, tlast=1}, cnt_abort=1.
  - → remaining 3 words flushed, cnt_loc=0.
- out_tready toggles 1/0 every cycle during a FWD packet.
  - → all 5 words delivered in order, no abort, source held by tready.
  - → cnt_abort=0, cnt_fwd=1.
- Assert rst_n=0 mid-packet, then preload cnt_drop near saturation.
  - → all outputs and counters 0 immediately.
  - → after 65536 bad packets cnt_drop stays 16'hFFFF.
